// File: rtl/bin_to_ssd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one shift per clock) driving a
// time-multiplexed, active-low seven-segment display with optional leading-zero blanking.
module bin_to_ssd_seq #(
    parameter int WIDTH       = 6,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int NW = 4 * DIGITS;
    localparam int SW = $clog2(WIDTH + 1);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] sreg;
    logic [NW-1:0]   scratch;
    logic [NW-1:0]   adjusted;
    logic [SW-1:0]   steps;
    logic [RW-1:0]   rcnt;
    logic [IW-1:0]   idx;
    logic [DIGITS-1:0] nonzero;
    logic [3:0]      digit;
    logic            blank;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        adjusted = scratch;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            scratch <= '0;
            sreg    <= '0;
            steps   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg    <= bin;
                        scratch <= '0;
                        steps   <= SW'(WIDTH);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, sreg} <= {adjusted, sreg} << 1;
                    steps <= steps - SW'(1);
                    if (steps == SW'(1))
                        state <= DONE;
                end
                DONE: begin
                    bcd   <= scratch;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Scan position is independent of conversions; only reset restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt <= '0;
            idx  <= '0;
        end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
            rcnt <= '0;
            idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            rcnt <= rcnt + RW'(1);
        end
    end

    // A digit is blanked when it and every more significant digit are zero.
    always_comb begin
        an      = '1;
        digit   = '0;
        blank   = 1'b0;
        nonzero = '0;
        for (int unsigned i = 0; i < DIGITS; i++)
            nonzero[i] = (bcd[4*i +: 4] != 4'd0);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                an[i] = 1'b0;
                digit = bcd[4*i +: 4];
                blank = (BLANK_LZ != 0) && (i != 0) && ((nonzero >> i) == '0);
            end
        end
        seg = blank ? 7'b1111111 : seg_of(digit);
    end

endmodule
